img_match_sad: RTL and testbench
================================

# img_match_sad

Frame-level template matcher sitting directly downstream of the camera pixel stream and alongside the 16x16 template lookup. Per pixel, it issues window-relative search coordinates to the template lookup and realigns the camera pixel to the returned template value. It then accumulates the sum of absolute differences (SAD) over a 256x256 window. At frame end it reports the SAD, the pixel count and a threshold match flag.

## Interface
- WIN_X0, 13'd0: window left edge in camera X.
- WIN_Y0, 13'd0: window top edge in camera Y.
- LOOKUP_LAT, 3: cycles from oSRCH_X/oSRCH_Y update to the matching iTPL value; legal range 1..8.
- ACC_W, 27: accumulator / oSAD width; legal range 20..32.
- THRESH, 27'd6553600: oMATCH asserted when oSAD < THRESH.

Ports (clock and reset first):
- iCLK  in  1  system clock; all logic on rising edge.
- iRST_N  in  1  asynchronous, active-low reset.
- iFVAL  in  1  frame valid.
- iDVAL  in  1  pixel valid.
- iX  in  13  camera pixel X.
- iY  in  13  camera pixel Y.
- iDATA  in  10  camera grey value.
- oSRCH_X  out  13  registered iX-WIN_X0 to the template lookup.
- oSRCH_Y  out  13  registered iY-WIN_Y0 to the template lookup.
- iTPL  in  10  template value returned by the lookup.
- oSAD  out  ACC_W  last completed frame SAD.
- oCNT  out  17  last completed frame accumulated-pixel count.
- oMATCH  out  1  oSAD < THRESH; updates with oSAD.
- oSAD_VALID  out  1  one-cycle pulse when oSAD/oCNT/oMATCH update.
- oBUSY  out  1  high in ACCUM and DRAIN.

## Operation
- Stage 0, every cycle:
  - Register oSRCH_X = iX-WIN_X0 and oSRCH_Y = iY-WIN_Y0 (13-bit, wrap allowed).
  - Register in_win = iDVAL & (iX>=WIN_X0) & (iX-WIN_X0<256) & (iY>=WIN_Y0) & (iY-WIN_Y0<256).
  - Register iDATA.
- Delay line of depth LOOKUP_LAT carries {in_win, data}, so it lines up with iTPL.
- Stage D, when the delayed in_win is set: diff = |data - iTPL|, 10-bit unsigned, registered.
- Stage A: add the registered diff to the accumulator when its valid bit is set and state is ACCUM or DRAIN; increment the pixel counter.
- State machine:
  - IDLE: on iFVAL rising, clear accumulator and counter, go to ACCUM.
  - ACCUM: on iFVAL falling, go to DRAIN.
  - DRAIN: count LOOKUP_LAT+2 cycles so all in-flight pixels retire, then go to REPORT.
  - REPORT: load oSAD, oCNT, oMATCH; pulse oSAD_VALID; go to IDLE.
- iFVAL rising outside IDLE: that frame is ignored entirely; no partial report.
- Pixels with iDVAL while in IDLE or REPORT are never accumulated.
- After reset release with iFVAL already high, wait for the next rising edge.

## Timing
- Reset values:
  - oSRCH_X = oSRCH_Y = 0; oSAD = 0; oCNT = 0; oMATCH = 0.
  - oSAD_VALID = 0; oBUSY = 0; state IDLE; pipeline valid bits cleared.
- Pixel-to-accumulator latency: 1 (stage 0) + LOOKUP_LAT + 1 (diff) + 1 (accumulate) cycles.
- oSAD_VALID is asserted LOOKUP_LAT+3 cycles after the iFVAL falling edge is sampled; it is high for exactly 1 cycle.
- oSAD, oCNT and oMATCH hold their values until the next REPORT.
- Reset asserted mid-frame: accumulator and outputs return to reset values immediately; no report is issued.
- oCNT maximum is 65536; its 17-bit width is sufficient.

## Configuration
- IMG_MATCH_SAT_EN defined: the accumulator saturates at 2^ACC_W-1, and further adds are held at that value.
- IMG_MATCH_SAT_EN not defined: the accumulator wraps modulo 2^ACC_W.
- oCNT is unaffected either way.

## Test plan
Bench lookup model returns iTPL LOOKUP_LAT cycles after oSRCH. Frames are 640x480, WIN_X0=WIN_Y0=0, LOOKUP_LAT=3.
- Frame with iDATA=429, model returns 429 everywhere -> oSAD=0, oCNT=65536, oMATCH=1, a single oSAD_VALID pulse 6 cycles after iFVAL falls.
- Frame with iDATA=0, model returns 1023 -> oSAD=67043328, oCNT=65536, oMATCH=0.
- WIN_X0=400 with a 640-wide frame, mismatching data -> oCNT=240*256=61440, and oSAD=61440*1023 for iDATA=0 / iTPL=1023.
- Frame matching everywhere except a single pixel at (5,7) with iDATA=100 and iTPL=0 -> oSAD=100, proving alignment; with the model delayed to 4 cycles, oSAD≠100.
- iRST_N pulsed low mid-frame, then one full matching frame -> no report for the interrupted frame; next report oSAD=0, oCNT=65536.
- ACC_W=20, all-diff frame (iDATA=0, iTPL=1023) -> oSAD=1048575 with IMG_MATCH_SAT_EN defined, 983040 without it.

Source files
------------

// File: rtl/img_match_sad.sv
// SAD template matcher: aligns camera pixels with the template lookup and accumulates |data - tpl| over a 256x256 window.
// Define IMG_MATCH_SAT_EN to saturate the accumulator instead of letting it wrap.
module img_match_sad #(
  parameter logic [12:0] WIN_X0     = 13'd0,
  parameter logic [12:0] WIN_Y0     = 13'd0,
  parameter int          LOOKUP_LAT = 3,
  parameter int          ACC_W      = 27,
  parameter logic [31:0] THRESH     = 32'd6553600
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic             iFVAL,
  input  logic             iDVAL,
  input  logic [12:0]      iX,
  input  logic [12:0]      iY,
  input  logic [9:0]       iDATA,
  output logic [12:0]      oSRCH_X,
  output logic [12:0]      oSRCH_Y,
  input  logic [9:0]       iTPL,
  output logic [ACC_W-1:0] oSAD,
  output logic [16:0]      oCNT,
  output logic             oMATCH,
  output logic             oSAD_VALID,
  output logic             oBUSY
);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, REPORT} state_t;

  localparam logic [3:0] DRAIN_LAST = 4'(LOOKUP_LAT + 1);

  function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
    logic signed [10:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    abs_diff = d[10] ? 10'(-d) : d[9:0];
  endfunction

  function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a, input logic [9:0] b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + {{(ACC_W-9){1'b0}}, b};
`ifdef IMG_MATCH_SAT_EN
    acc_add = s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
`else
    acc_add = s[ACC_W-1:0];
`endif
  endfunction

  state_t                state, next_state;
  logic                  fval_q, rise, fall, start;
  logic [3:0]            drain_cnt;
  logic [12:0]           rel_x, rel_y;
  logic                  accept;
  logic                  vld_p0;
  logic [9:0]            data_p0;
  logic [LOOKUP_LAT-1:0] vld_p1;
  logic [9:0]            data_p1 [LOOKUP_LAT];
  logic                  vld_p2;
  logic [9:0]            diff_p2;
  logic [ACC_W-1:0]      acc;
  logic [16:0]           cnt;

  assign rise = iFVAL & ~fval_q;
  assign fall = ~iFVAL & fval_q;

  // fval_q resets high so a frame already in progress at reset release is skipped
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      fval_q <= 1'b1;
      state  <= IDLE;
    end else begin
      fval_q <= iFVAL;
      state  <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    start      = 1'b0;
    case (state)
      IDLE:    if (rise) begin
                 next_state = ACCUM;
                 start      = 1'b1;
               end
      ACCUM:   if (fall) next_state = DRAIN;
      DRAIN:   if (drain_cnt == DRAIN_LAST) next_state = REPORT;
      REPORT:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign oBUSY = (state == ACCUM) || (state == DRAIN);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) drain_cnt <= 4'd0;
    else if (state != DRAIN) drain_cnt <= 4'd0;
    else drain_cnt <= drain_cnt + 4'd1;
  end

  // Stage 0: window test, search coordinates, data capture
  assign rel_x  = iX - WIN_X0;
  assign rel_y  = iY - WIN_Y0;
  assign accept = iDVAL && (iX >= WIN_X0) && (rel_x[12:8] == 5'd0) &&
                  (iY >= WIN_Y0) && (rel_y[12:8] == 5'd0) &&
                  ((state == ACCUM) || start);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oSRCH_X <= '0;
      oSRCH_Y <= '0;
      vld_p0  <= 1'b0;
    end else begin
      oSRCH_X <= rel_x;
      oSRCH_Y <= rel_y;
      vld_p0  <= accept;
    end
  end

  always_ff @(posedge iCLK) data_p0 <= iDATA;

  // Stage 1: delay line matching the lookup latency
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) vld_p1 <= '0;
    else begin
      vld_p1[0] <= vld_p0;
      for (int i = 1; i < LOOKUP_LAT; i++) vld_p1[i] <= vld_p1[i-1];
    end
  end

  always_ff @(posedge iCLK) begin
    data_p1[0] <= data_p0;
    for (int i = 1; i < LOOKUP_LAT; i++) data_p1[i] <= data_p1[i-1];
  end

  // Stage 2: absolute difference against the returned template value
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) vld_p2 <= 1'b0;
    else vld_p2 <= vld_p1[LOOKUP_LAT-1];
  end

  always_ff @(posedge iCLK) begin
    if (vld_p1[LOOKUP_LAT-1]) diff_p2 <= abs_diff(data_p1[LOOKUP_LAT-1], iTPL);
  end

  // Stage 3: accumulate
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      acc <= '0;
      cnt <= '0;
    end else if (start) begin
      acc <= '0;
      cnt <= '0;
    end else if (vld_p2 && oBUSY) begin
      acc <= acc_add(acc, diff_p2);
      cnt <= cnt + 17'd1;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oSAD       <= '0;
      oCNT       <= '0;
      oMATCH     <= 1'b0;
      oSAD_VALID <= 1'b0;
    end else begin
      oSAD_VALID <= (state == REPORT);
      if (state == REPORT) begin
        oSAD   <= acc;
        oCNT   <= cnt;
        oMATCH <= (32'(acc) < THRESH);
      end
    end
  end

endmodule

// File: tb/tb_img_match_sad.sv
// Scoreboard bench for img_match_sad: directed frames queue expected reports; a monitor checks each oSAD_VALID pulse.
module tb_img_match_sad;

  localparam int LAT   = 3;
  localparam int ACC_W = 20;

  logic             iCLK = 1'b0;
  logic             iRST_N = 1'b0;
  logic             iFVAL = 1'b0;
  logic             iDVAL = 1'b0;
  logic [12:0]      iX = '0;
  logic [12:0]      iY = '0;
  logic [9:0]       iDATA = '0;
  logic [9:0]       iTPL;
  logic [12:0]      oSRCH_X, oSRCH_Y;
  logic [ACC_W-1:0] oSAD;
  logic [16:0]      oCNT;
  logic             oMATCH, oSAD_VALID, oBUSY;

  img_match_sad #(
    .WIN_X0(13'd400), .WIN_Y0(13'd8), .LOOKUP_LAT(LAT), .ACC_W(ACC_W), .THRESH(32'd5000)
  ) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iFVAL(iFVAL), .iDVAL(iDVAL), .iX(iX), .iY(iY),
    .iDATA(iDATA), .oSRCH_X(oSRCH_X), .oSRCH_Y(oSRCH_Y), .iTPL(iTPL), .oSAD(oSAD),
    .oCNT(oCNT), .oMATCH(oMATCH), .oSAD_VALID(oSAD_VALID), .oBUSY(oBUSY)
  );

  always #5 iCLK = ~iCLK;

  int cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  int         lat_sel = LAT;
  bit         tpl_mode = 1'b0;
  logic [9:0] tpl_const = '0;
  logic [9:0] data_const = '0;
  bit         poke_en = 1'b0;
  int         poke_x = 0, poke_y = 0;
  logic [9:0] poke_val = '0;

  function automatic logic [9:0] tpl_fn(input logic [12:0] sx, input logic [12:0] sy);
    logic [12:0] t;
    t = sx + {sy[11:0], 1'b0};
    return t[9:0];
  endfunction

  function automatic logic [9:0] data_at(input int x, input int y);
    if (poke_en && x == poke_x && y == poke_y) return poke_val;
    if (tpl_mode) return data_const;
    return tpl_fn(13'(x - 400), 13'(y - 8));
  endfunction

  // Template lookup model: value appears lat_sel cycles after the search coordinates
  logic [9:0] tpl_pipe [8];
  always @(posedge iCLK) begin
    tpl_pipe[0] <= tpl_mode ? tpl_const : tpl_fn(oSRCH_X, oSRCH_Y);
    for (int i = 1; i < 8; i++) tpl_pipe[i] <= tpl_pipe[i-1];
  end
  assign iTPL = tpl_pipe[lat_sel-1];

  typedef struct {
    string  name;
    longint sad;
    longint cnt;
    bit     match;
    bit     neq;
    int     vcyc;
  } exp_t;
  exp_t sb[$];
  exp_t cur;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic expect_rep(input string nm, input longint sad, input longint cnt,
                            input bit m, input bit neq, input int fe);
    exp_t e;
    e.name = nm; e.sad = sad; e.cnt = cnt; e.match = m; e.neq = neq; e.vcyc = fe + LAT + 3;
    sb.push_back(e);
  endtask

  always @(negedge iCLK) begin
    if (iRST_N && oSAD_VALID) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_report actual_sad=%0d actual_cnt=%0d expected=none", oSAD, oCNT);
      end else begin
        cur = sb.pop_front();
        if (cur.neq) begin
          checks++;
          if (longint'(oSAD) == cur.sad) begin
            errors++;
            $display("FAIL %s_sad actual=%0d expected_not=%0d", cur.name, oSAD, cur.sad);
          end
        end else chk({cur.name, "_sad"}, longint'(oSAD), cur.sad);
        chk({cur.name, "_cnt"}, longint'(oCNT), cur.cnt);
        chk({cur.name, "_match"}, longint'(oMATCH), longint'(cur.match));
        chk({cur.name, "_time"}, longint'(cyc), longint'(cur.vcyc));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge iCLK);
  endtask

  task automatic run_frame(output int fe, input int x0, input int y0, input int w, input int h);
    iFVAL = 1'b1;
    iDVAL = 1'b0;
    @(negedge iCLK);
    for (int y = y0; y < y0 + h; y++) begin
      for (int x = x0; x < x0 + w; x++) begin
        iDVAL = 1'b1;
        iX    = 13'(x);
        iY    = 13'(y);
        iDATA = data_at(x, y);
        @(negedge iCLK);
      end
    end
    iDVAL = 1'b0;
    iFVAL = 1'b0;
    fe = cyc + 1;
    @(negedge iCLK);
  endtask

  task automatic drive_row(input int x0, input int y, input int w);
    for (int x = x0; x < x0 + w; x++) begin
      iDVAL = 1'b1;
      iX    = 13'(x);
      iY    = 13'(y);
      iDATA = data_at(x, y);
      @(negedge iCLK);
    end
    iDVAL = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout actual=cycle_%0d expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int fe;
    iRST_N = 1'b0;
    idle(3);
    chk("rst_srch_x", oSRCH_X, 0);
    chk("rst_srch_y", oSRCH_Y, 0);
    chk("rst_sad", oSAD, 0);
    chk("rst_cnt", oCNT, 0);
    chk("rst_match", oMATCH, 0);
    chk("rst_valid", oSAD_VALID, 0);
    chk("rst_busy", oBUSY, 0);
    iRST_N = 1'b1;
    idle(3);
    chk("idle_busy", oBUSY, 0);

    tpl_mode = 1'b1; data_const = 10'd429; tpl_const = 10'd429;
    run_frame(fe, 400, 8, 16, 16);
    chk("accum_busy", oBUSY, 1);
    expect_rep("match429", 0, 256, 1'b1, 1'b0, fe);
    idle(20);

    data_const = 10'd0; tpl_const = 10'd1023;
    run_frame(fe, 400, 8, 16, 4);
    expect_rep("diffmax", 65472, 64, 1'b0, 1'b0, fe);
    idle(20);

    // Reset in the middle of a frame, frame still high on release
    tpl_mode = 1'b0;
    iFVAL = 1'b1;
    @(negedge iCLK);
    drive_row(400, 8, 40);
    iRST_N = 1'b0;
    #1;
    chk("midrst_sad", oSAD, 0);
    chk("midrst_cnt", oCNT, 0);
    chk("midrst_busy", oBUSY, 0);
    chk("midrst_srch_x", oSRCH_X, 0);
    idle(2);
    iRST_N = 1'b1;
    drive_row(400, 9, 40);
    chk("postrst_busy", oBUSY, 0);
    iFVAL = 1'b0;
    idle(20);

    run_frame(fe, 400, 8, 256, 256);
    expect_rep("full", 0, 65536, 1'b1, 1'b0, fe);
    idle(20);

    tpl_mode = 1'b1; data_const = 10'd0; tpl_const = 10'd1023;
    run_frame(fe, 396, 6, 8, 4);
    expect_rep("edge_lt", 8184, 8, 1'b0, 1'b0, fe);
    idle(20);

    data_const = 10'd10; tpl_const = 10'd3;
    run_frame(fe, 652, 262, 8, 4);
    expect_rep("edge_rb", 56, 8, 1'b1, 1'b0, fe);
    idle(20);

    tpl_mode = 1'b0; poke_en = 1'b1; poke_x = 405; poke_y = 15; poke_val = 10'd119;
    run_frame(fe, 400, 8, 32, 8);
    expect_rep("align", 100, 256, 1'b1, 1'b0, fe);
    idle(20);

    lat_sel = 4;
    run_frame(fe, 400, 8, 32, 8);
    expect_rep("misalign", 100, 256, 1'b1, 1'b1, fe);
    idle(20);
    lat_sel = LAT; poke_en = 1'b0;

    // Rising edge during DRAIN: that frame must leave no trace
    tpl_mode = 1'b1; data_const = 10'd0; tpl_const = 10'd1023;
    run_frame(fe, 400, 8, 4, 1);
    expect_rep("pre_ignored", 4092, 4, 1'b1, 1'b0, fe);
    iFVAL = 1'b1;
    drive_row(400, 9, 20);
    iFVAL = 1'b0;
    idle(20);

    run_frame(fe, 400, 8, 57, 18);
`ifdef IMG_MATCH_SAT_EN
    expect_rep("overflow", 1048575, 1026, 1'b0, 1'b0, fe);
`else
    expect_rep("overflow", 1022, 1026, 1'b1, 1'b0, fe);
`endif
    idle(20);

    run_frame(fe, 400, 8, 25, 41);
    expect_rep("acc_full", 1048575, 1025, 1'b0, 1'b0, fe);
    idle(20);

    data_const = 10'd500; tpl_const = 10'd0;
    run_frame(fe, 400, 8, 10, 1);
    expect_rep("thresh_eq", 5000, 10, 1'b0, 1'b0, fe);
    idle(30);

    chk("pending_reports", longint'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
